// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared definitions for the fetch PC sequencer: the sequencer state
//   encoding, default boot and exception vectors, and the sequential-fetch
//   PC increment.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_seq_state_e;

  localparam logic [31:0] PC_SEQ_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_SEQ_EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] PC_SEQ_PC_INC       = 32'd4;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch PC sequencer for a single-issue pipeline with a branch delay slot.
//   Steps the PC by 4 each unstalled cycle, redirects to a resolved branch
//   target one cycle after the unstalled resolve, and parks a target that
//   resolves during a stall until the stall releases.
//
//   Optional feature macro: PC_SEQ_EXC_EN
//     Defined   -> ExcReq/ExcPC inputs and EPC output exist; an exception
//                  redirects fetch to EXC_VECTOR and flushes IF and ID.
//     Undefined -> no exception ports or logic.
//
//   Ports
//     Clock      in   rising-edge clock
//     Reset      in   synchronous, active-high reset
//     Stall      in   fetch/pipeline hold request
//     BrValid    in   control-transfer resolved in execute this cycle
//     BrTaken    in   branch taken (ignored unless BrValid)
//     BrTarget   in   branch target address (no alignment check)
//     ExcReq     in   exception request            (PC_SEQ_EXC_EN only)
//     ExcPC      in   PC of the faulting instruction (PC_SEQ_EXC_EN only)
//     EPC        out  captured exception PC         (PC_SEQ_EXC_EN only)
//     PC         out  current fetch address
//     FetchValid out  PC is a valid fetch this cycle
//     FlushIF    out  kill the instruction in fetch
//     FlushID    out  kill the instruction in decode
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   BOOT  | first cycle after reset; PC parked at RESET_VECTOR, no fetch
//   RUN   | normal fetch; PC+4, hold on stall, redirect on taken branch
//   PEND  | taken branch resolved while stalled; target held until release
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_SEQ_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = PC_SEQ_EXC_VECTOR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BrValid,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
`ifdef PC_SEQ_EXC_EN
  input  logic        ExcReq,
  input  logic [31:0] ExcPC,
  output logic [31:0] EPC,
`endif
  output logic [31:0] PC,
  output logic        FetchValid,
  output logic        FlushIF,
  output logic        FlushID
);

  pc_seq_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   target_q, target_d;
  logic          redirect;
  logic          flush_if;
  logic          flush_id;

`ifdef PC_SEQ_EXC_EN
  logic [31:0]   epc_q, epc_d;
  logic          exc_take;

  // Exceptions are only honoured once the sequencer is out of BOOT.
  assign exc_take = ExcReq & (state_q != BOOT);
`endif

  assign redirect = BrValid & BrTaken;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      target_q <= '0;
`ifdef PC_SEQ_EXC_EN
      epc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
`ifdef PC_SEQ_EXC_EN
      epc_q    <= epc_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    flush_if = 1'b0;
    flush_id = 1'b0;
`ifdef PC_SEQ_EXC_EN
    epc_d    = epc_q;
`endif

    case (state_q)
      BOOT: begin
        pc_d    = RESET_VECTOR;
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          if (Stall) begin
            // The delay-slot fetch is still held at PC; park the target.
            target_d = BrTarget;
            state_d  = PEND;
          end else begin
            // Kill only the fall-through fetch; the delay slot in decode
            // still executes.
            pc_d     = BrTarget;
            flush_if = 1'b1;
          end
        end else if (!Stall) begin
          pc_d = pc_q + PC_SEQ_PC_INC;
        end
      end
      PEND: begin
        if (!Stall) begin
          pc_d     = target_q;
          flush_if = 1'b1;
          state_d  = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

`ifdef PC_SEQ_EXC_EN
    // Exception outranks both redirect and stall; a parked target is lost.
    if (exc_take) begin
      pc_d     = EXC_VECTOR;
      epc_d    = ExcPC;
      target_d = '0;
      flush_if = 1'b1;
      flush_id = 1'b1;
      state_d  = RUN;
    end
`endif

    // Flushes describe the next-state transition, which reset overrides.
    if (Reset) begin
      flush_if = 1'b0;
      flush_id = 1'b0;
    end
  end

  assign PC         = pc_q;
  assign FetchValid = (state_q != BOOT);
  assign FlushIF    = flush_if;
  assign FlushID    = flush_id;
`ifdef PC_SEQ_EXC_EN
  assign EPC        = epc_q;
`endif

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed scenarios plus randomized traffic for pc_sequencer, compared each
//   cycle against a behavioural model of the fetch sequencing rules. Builds
//   with or without PC_SEQ_EXC_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] EV = 32'hBFC0_0380;
`ifdef PC_SEQ_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        BrValid = 1'b0;
  logic        BrTaken = 1'b0;
  logic [31:0] BrTarget = '0;
  logic        exc_req_i = 1'b0;
  logic [31:0] exc_pc_i = '0;
  logic [31:0] PC;
  logic        FetchValid, FlushIF, FlushID;
  logic [31:0] epc_o;

  always #5 Clock = ~Clock;

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Stall      (Stall),
    .BrValid    (BrValid),
    .BrTaken    (BrTaken),
    .BrTarget   (BrTarget),
`ifdef PC_SEQ_EXC_EN
    .ExcReq     (exc_req_i),
    .ExcPC      (exc_pc_i),
    .EPC        (epc_o),
`endif
    .PC         (PC),
    .FetchValid (FetchValid),
    .FlushIF    (FlushIF),
    .FlushID    (FlushID)
  );

`ifndef PC_SEQ_EXC_EN
  assign epc_o = '0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: fetch address, boot/pending flags, parked target, EPC.
  logic [31:0] m_pc, m_tgt, m_epc;
  bit          m_boot, m_pend;
  bit          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic drive(input bit rst, input bit st, input bit bv, input bit bt,
                       input logic [31:0] tgt, input bit er, input logic [31:0] epc);
    Reset     = rst;
    Stall     = st;
    BrValid   = bv;
    BrTaken   = bt;
    BrTarget  = tgt;
    exc_req_i = EXC_EN ? er : 1'b0;
    exc_pc_i  = epc;
    @(negedge Clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // Compare all outputs with the model, then clock and advance the model.
  task automatic tick();
    bit exc, redir, e_fif, e_fid;
    exc   = EXC_EN && exc_req_i && !m_boot;
    redir = BrValid && BrTaken;
    e_fif = !Reset && (exc || (m_pend && !Stall) || (!m_boot && !m_pend && redir && !Stall));
    e_fid = !Reset && exc;
    if (m_valid) begin
      chk("pc", PC, m_pc);
      chk("fetch_valid", {31'b0, FetchValid}, {31'b0, !m_boot});
      chk("flush_if", {31'b0, FlushIF}, {31'b0, e_fif});
      chk("flush_id", {31'b0, FlushID}, {31'b0, e_fid});
      if (EXC_EN) chk("epc", epc_o, m_epc);
    end
    @(posedge Clock);
    if (Reset) begin
      m_valid = 1'b1;
      m_boot  = 1'b1;
      m_pend  = 1'b0;
      m_pc    = RV;
      m_tgt   = '0;
      m_epc   = '0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (exc) begin
      m_pc   = EV;
      m_epc  = exc_pc_i;
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (!Stall) begin
        m_pc   = m_tgt;
        m_pend = 1'b0;
      end
    end else if (redir) begin
      if (Stall) begin
        m_tgt  = BrTarget;
        m_pend = 1'b1;
      end else begin
        m_pc = BrTarget;
      end
    end else if (!Stall) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    logic [31:0] p;

    // Reset for two cycles, boot, then sequential fetch.
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    idle(); chk("boot_pc", PC, RV); chk("boot_fv", {31'b0, FetchValid}, 32'd0); tick();
    idle(); chk("run0_pc", PC, RV); chk("run0_fv", {31'b0, FetchValid}, 32'd1); tick();
    idle(); chk("run1_pc", PC, 32'hBFC0_0004); tick();
    idle(); chk("run2_pc", PC, 32'hBFC0_0008); tick();
    idle(); tick();

    // Unstalled taken branch at BFC00010.
    drive(0, 0, 1, 1, 32'h0040_0100, 0, 32'h0);
    chk("br_at_pc", PC, 32'hBFC0_0010);
    chk("br_flush_if", {31'b0, FlushIF}, 32'd1);
    chk("br_flush_id", {31'b0, FlushID}, 32'd0);
    tick();
    idle(); chk("br_tgt_pc", PC, 32'h0040_0100); tick();
    idle(); chk("br_tgt_pc4", PC, 32'h0040_0104); tick();

    // Taken branch under a 3-cycle stall.
    drive(0, 1, 1, 1, 32'h0040_0100, 0, 32'h0);
    p = PC;
    chk("stbr_flush_if", {31'b0, FlushIF}, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, i[0], 1, 32'h1234_5670, 0, 32'h0);
      chk("pend_hold_pc", PC, p);
      chk("pend_flush_if", {31'b0, FlushIF}, 32'd0);
      tick();
    end
    idle();
    chk("pend_rel_flush", {31'b0, FlushIF}, 32'd1);
    chk("pend_rel_pc", PC, p);
    tick();
    idle(); chk("pend_tgt_pc", PC, 32'h0040_0100); tick();

    // BrTaken without BrValid is not a redirect.
    drive(0, 0, 0, 1, 32'hDEAD_BEEC, 0, 32'h0);
    p = PC;
    chk("nobv_flush", {31'b0, FlushIF}, 32'd0);
    tick();
    idle(); chk("nobv_pc4", PC, p + 32'd4); tick();

    // 32-bit wrap.
    drive(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0); tick();
    idle(); chk("wrap_m8", PC, 32'hFFFF_FFF8); tick();
    idle(); chk("wrap_m4", PC, 32'hFFFF_FFFC); tick();
    idle(); chk("wrap_0", PC, 32'h0000_0000); tick();

    // Unaligned target passes through.
    drive(0, 0, 1, 1, 32'h0040_0103, 0, 32'h0); tick();
    idle(); chk("unal_pc", PC, 32'h0040_0103); tick();
    idle(); chk("unal_pc4", PC, 32'h0040_0107); tick();

`ifdef PC_SEQ_EXC_EN
    // Exception while PEND and stalled.
    drive(0, 1, 1, 1, 32'h0040_0100, 0, 32'h0); tick();
    drive(0, 1, 1, 1, 32'h0055_0000, 1, 32'h0040_0200);
    chk("exc_flush_if", {31'b0, FlushIF}, 32'd1);
    chk("exc_flush_id", {31'b0, FlushID}, 32'd1);
    tick();
    idle();
    chk("exc_pc", PC, EV);
    chk("exc_epc", epc_o, 32'h0040_0200);
    chk("exc_drop_flush", {31'b0, FlushIF}, 32'd0);
    tick();
    idle(); chk("exc_pc4", PC, EV + 32'd4); tick();
`endif

    // Reset while PEND discards the parked target.
    drive(0, 1, 1, 1, 32'h0040_0100, 0, 32'h0); tick();
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0); tick();
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    idle(); chk("rstp_pc", PC, RV); chk("rstp_fv", {31'b0, FetchValid}, 32'd0); tick();
    idle(); chk("rstp_run_pc", PC, RV); chk("rstp_flush", {31'b0, FlushIF}, 32'd0); tick();
    idle(); chk("rstp_pc4", PC, RV + 32'd4); tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1) == 1,
            $urandom,
            ($urandom_range(0, 19) == 0),
            $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pc_sequencer
